mpuf_arbiter_voter: RTL and testbench

- Synchronous response-capture and majority-vote sequencer for the multi-PUF arbiter bank.
- Per run, it repeatedly clears the arbiter flip-flops, fires the challenge and samples N_CH arbiter outputs. It does this N_EVAL times and accumulates a per-channel ones-count.
- Reports a majority-voted response, a per-channel stability (unanimity) mask and the XOR-combined multi-PUF bit.
- Sits between the challenge controller and the arbiter race flip-flops.

---
 rtl/mpuf_arbiter_voter.sv | 152 +++++++++++++++
 tb/tb_mpuf_arbiter_voter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mpuf_arbiter_voter.sv
// Response-capture and majority-vote sequencer for the multi-PUF arbiter bank.
// Repeats clear/launch/sample N_EVAL times, then reports vote, stability and XOR bit.
module mpuf_arbiter_voter #(
  parameter int N_CH    = 4,
  parameter int N_EVAL  = 5,
  parameter int CLR_CYC = 2,
  parameter int TIMEOUT = 8
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            start,
  output logic            launch,
  output logic            arb_clr,
  input  logic [N_CH-1:0] resp_in,
  input  logic            resp_valid,
  output logic [N_CH-1:0] vote_out,
  output logic [N_CH-1:0] stable,
  output logic            xor_out,
  output logic            done,
  output logic            busy,
  output logic            timeout_err
);

  localparam int CW   = $clog2(N_EVAL + 1);
  localparam int TMAX = (CLR_CYC > TIMEOUT) ? CLR_CYC : TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   count [N_CH];
  logic [CW-1:0]   eval_cnt;
  logic [TW-1:0]   timer;
  logic            abort;
  logic            last_eval;
  logic [N_CH-1:0] vote_nxt;
  logic [N_CH-1:0] stable_nxt;

  assign last_eval = (eval_cnt == CW'(N_EVAL - 1));

  always_comb begin
    vote_nxt   = '0;
    stable_nxt = '0;
    for (int ch = 0; ch < N_CH; ch++) begin
      vote_nxt[ch]   = (count[ch] > CW'(N_EVAL / 2));
      stable_nxt[ch] = (count[ch] == '0) || (count[ch] == CW'(N_EVAL));
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // The timer is shared: it counts the clear window in CLEAR and the response window in WAIT.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    arb_clr   = 1'b0;
    busy      = 1'b1;
    case (state)
      S_IDLE: begin
        arb_clr = 1'b1;
        busy    = 1'b0;
        if (start) state_nxt = S_CLEAR;
      end
      S_CLEAR: begin
        arb_clr = 1'b1;
        if (timer == '0) state_nxt = S_LAUNCH;
      end
      S_LAUNCH: begin
        launch    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (resp_valid)        state_nxt = last_eval ? S_DONE : S_CLEAR;
        else if (timer == '0)  state_nxt = S_DONE;
      end
      S_DONE: begin
        arb_clr   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int ch = 0; ch < N_CH; ch++) count[ch] <= '0;
      eval_cnt    <= '0;
      timer       <= '0;
      abort       <= 1'b0;
      vote_out    <= '0;
      stable      <= '0;
      xor_out     <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            for (int ch = 0; ch < N_CH; ch++) count[ch] <= '0;
            eval_cnt    <= '0;
            abort       <= 1'b0;
            timeout_err <= 1'b0;
            timer       <= TW'(CLR_CYC - 1);
          end
        end
        S_CLEAR: begin
          if (timer != '0) timer <= timer - TW'(1);
        end
        S_LAUNCH: begin
          timer <= TW'(TIMEOUT - 1);
        end
        S_WAIT: begin
          if (resp_valid) begin
            for (int ch = 0; ch < N_CH; ch++)
              count[ch] <= count[ch] + CW'(resp_in[ch]);
            eval_cnt <= eval_cnt + CW'(1);
            timer    <= TW'(CLR_CYC - 1);
          end else if (timer == '0) begin
            abort <= 1'b1;
          end else begin
            timer <= timer - TW'(1);
          end
        end
        S_DONE: begin
          done <= 1'b1;
          if (abort) begin
            vote_out    <= '0;
            stable      <= '0;
            xor_out     <= 1'b0;
            timeout_err <= 1'b1;
          end else begin
            vote_out <= vote_nxt;
            stable   <= stable_nxt;
            xor_out  <= ^vote_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mpuf_arbiter_voter.sv
// Randomized self-checking bench for mpuf_arbiter_voter against a per-run ones-count model.
// Timing expectations are derived from the clear/launch/wait cycle budget of each evaluation.
module tb_mpuf_arbiter_voter;
  localparam int N_CH    = 4;
  localparam int N_EVAL  = 5;
  localparam int CLR_CYC = 2;
  localparam int TIMEOUT = 8;

  logic            clk = 1'b0;
  logic            clr, start, launch, arb_clr, resp_valid;
  logic            xor_out, done, busy, timeout_err;
  logic [N_CH-1:0] resp_in, vote_out, stable;

  int errors = 0;
  int checks = 0;
  logic [N_CH-1:0] pat [N_EVAL];
  bit              chain;

  mpuf_arbiter_voter #(
    .N_CH(N_CH), .N_EVAL(N_EVAL), .CLR_CYC(CLR_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .launch(launch), .arb_clr(arb_clr),
    .resp_in(resp_in), .resp_valid(resp_valid), .vote_out(vote_out),
    .stable(stable), .xor_out(xor_out), .done(done), .busy(busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0 = normal run, 1 = no responses (timeout), 2 = clr during the third WAIT
  task automatic applyStimulus(input string name, input int mode, input bit noise,
                               input bit rand_delay, input bit pre_started, input bit b2b);
    int cnt [N_CH];
    int k, anchor, wait_start, dly, ev, nlaunch, exp_done;
    bit in_wait, finished;
    logic [15:0] hist;
    logic [N_CH-1:0] ev_vote, ev_stable;
    logic ev_xor, ev_terr;
    for (int ch = 0; ch < N_CH; ch++) cnt[ch] = 0;
    anchor = 0; wait_start = 0; dly = 0; ev = 0; nlaunch = 0; exp_done = -1;
    in_wait = 0; finished = 0; hist = '0;
    ev_vote = '0; ev_stable = '0; ev_xor = 0; ev_terr = 0;
    if (!pre_started) start = 1'b1;
    step();
    k = 0;
    start = 1'b0;
    resp_valid = 1'b0;
    checkOutput({name, ":busy_at_start"}, busy, 1);
    checkOutput({name, ":terr_cleared"}, timeout_err, 0);
    hist = {hist[14:0], arb_clr};
    for (int guard = 0; guard < 400 && !finished; guard++) begin
      step();
      k++;
      if (launch) begin
        nlaunch++;
        checkOutput({name, ":launch_edge"}, k, anchor + CLR_CYC);
        checkOutput({name, ":arbclr_low_at_launch"}, arb_clr, 0);
        checkOutput({name, ":arbclr_before_launch"}, hist[CLR_CYC-1:0], (1 << CLR_CYC) - 1);
        in_wait    = 1;
        wait_start = k + 1;
        dly        = rand_delay ? $urandom_range(0, 3) : 0;
        if (mode == 1) exp_done = wait_start + TIMEOUT + 1;
      end
      hist = {hist[14:0], arb_clr};
      if (mode == 2 && in_wait && nlaunch == 3 && k == wait_start) begin
        clr = 1'b1;
        #1;
        checkOutput({name, ":rst_busy"}, busy, 0);
        checkOutput({name, ":rst_arbclr"}, arb_clr, 1);
        checkOutput({name, ":rst_launch"}, launch, 0);
        checkOutput({name, ":rst_vote"}, vote_out, 0);
        checkOutput({name, ":rst_stable"}, stable, 0);
        checkOutput({name, ":rst_xor"}, xor_out, 0);
        checkOutput({name, ":rst_done"}, done, 0);
        checkOutput({name, ":rst_terr"}, timeout_err, 0);
        clr = 1'b0;
        resp_valid = 1'b0;
        start = 1'b0;
        finished = 1;
      end else if (done) begin
        if (mode == 1) begin
          ev_vote = '0; ev_stable = '0; ev_xor = 0; ev_terr = 1;
        end else begin
          for (int ch = 0; ch < N_CH; ch++) begin
            ev_vote[ch]   = (cnt[ch] * 2 > N_EVAL);
            ev_stable[ch] = (cnt[ch] == 0) || (cnt[ch] == N_EVAL);
          end
          ev_xor  = ^ev_vote;
          ev_terr = 0;
        end
        checkOutput({name, ":done_edge"}, k, exp_done);
        checkOutput({name, ":launches"}, nlaunch, (mode == 1) ? 1 : N_EVAL);
        checkOutput({name, ":vote"}, vote_out, ev_vote);
        checkOutput({name, ":stable"}, stable, ev_stable);
        checkOutput({name, ":xor"}, xor_out, ev_xor);
        checkOutput({name, ":timeout_err"}, timeout_err, ev_terr);
        checkOutput({name, ":busy_done"}, busy, 0);
        resp_valid = 1'b0;
        start = b2b;
        finished = 1;
      end else begin
        resp_valid = 1'b0;
        if (noise) resp_in = N_CH'($urandom);
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        if (in_wait && mode != 1 && k == wait_start + dly) begin
          resp_valid = 1'b1;
          resp_in    = pat[ev];
          for (int ch = 0; ch < N_CH; ch++) cnt[ch] += pat[ev][ch];
          ev++;
          anchor  = k + 1;
          in_wait = 0;
          if (ev == N_EVAL) exp_done = k + 2;
        end else if (!in_wait && noise) begin
          resp_valid = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!finished) checkOutput({name, ":done_seen"}, done, 1);
    if (mode != 2 && !b2b) begin
      step();
      checkOutput({name, ":done_one_cycle"}, done, 0);
      checkOutput({name, ":idle_busy"}, busy, 0);
      checkOutput({name, ":vote_hold"}, vote_out, ev_vote);
      checkOutput({name, ":stable_hold"}, stable, ev_stable);
    end
  endtask

  task automatic setConst(input logic [N_CH-1:0] v);
    for (int e = 0; e < N_EVAL; e++) pat[e] = v;
  endtask

  task automatic setCh0(input logic [N_EVAL-1:0] seq);
    for (int e = 0; e < N_EVAL; e++) pat[e] = {{(N_CH-1){1'b0}}, seq[e]};
  endtask

  initial begin
    clr = 1'b1; start = 1'b0; resp_in = '0; resp_valid = 1'b0;
    step();
    step();
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_arbclr", arb_clr, 1);
    checkOutput("reset_launch", launch, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_vote", vote_out, 0);
    checkOutput("reset_stable", stable, 0);
    checkOutput("reset_terr", timeout_err, 0);
    clr = 1'b0;
    step();

    setConst(4'b1010);
    applyStimulus("s1_const", 0, 0, 0, 0, 0);
    setCh0(5'b01011);
    applyStimulus("s2_ch0_three", 0, 0, 0, 0, 0);
    setCh0(5'b01001);
    applyStimulus("s2_ch0_two", 0, 0, 1, 0, 0);
    applyStimulus("s3_timeout", 1, 0, 0, 0, 0);
    setConst(4'b1010);
    applyStimulus("s3_recover", 0, 0, 0, 0, 0);
    applyStimulus("s4_clr_mid", 2, 0, 0, 0, 0);
    applyStimulus("s4_rerun", 0, 0, 0, 0, 0);
    applyStimulus("s5_busy_start", 0, 1, 0, 0, 1);
    applyStimulus("s5_b2b_run", 0, 0, 0, 1, 0);
    applyStimulus("s6_noise", 0, 1, 0, 0, 0);

    chain = 0;
    for (int r = 0; r < 10; r++) begin
      bit nb;
      for (int e = 0; e < N_EVAL; e++) pat[e] = N_CH'($urandom);
      nb = (r < 9) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (r == 4) applyStimulus("rand_timeout", 1, 1, 1, chain, nb);
      else        applyStimulus("rand_run", 0, 1, 1, chain, nb);
      chain = nb;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
